// File: rtl/readout_check_pkg.sv
// Shared encodings, record field positions and helper functions for the
// readout frame checker.
package readout_check_pkg;

  localparam logic [15:0] HDR_MARKER_DEF = 16'h3C5C;
  localparam int          CRC_WORD_W     = 40;
  localparam logic [7:0]  CRC_POLY       = 8'h07;

  typedef enum logic [1:0] {
    TYPE_HEADER  = 2'b00,
    TYPE_DATA    = 2'b01,
    TYPE_TRAILER = 2'b10,
    TYPE_IDLE    = 2'b11
  } data_type_e;

  typedef enum logic [2:0] {
    ERR_GOOD           = 3'd0,
    ERR_NO_TRAILER     = 3'd1,
    ERR_NO_HEADER      = 3'd2,
    ERR_COUNT_MISMATCH = 3'd3,
    ERR_CRC_MISMATCH   = 3'd4,
    ERR_HEADER         = 3'd5,
    ERR_IDLE           = 3'd6,
    ERR_OVERFLOW       = 3'd7
  } frame_err_e;

  localparam int HDR_BCID_LO  = 0;
  localparam int DATA_BCID_LO = 9;
  localparam int BCID_W       = 12;
  localparam int TRL_L1_LO    = 20;
  localparam int TRL_SEU_BIT  = 19;
  localparam int TRL_CNT_LO   = 8;

  // Index of each event counter in the counter bank
  localparam int CNT_GOOD      = 0;
  localparam int CNT_NOT_HIT   = 1;
  localparam int CNT_NULL      = 2;
  localparam int CNT_FRAME_ERR = 3;
  localparam int CNT_BCID      = 4;
  localparam int CNT_HIT_MIS   = 5;
  localparam int CNT_L1_OVF    = 6;
  localparam int CNT_L1_FULL   = 7;
  localparam int CNT_L1_HALF   = 8;
  localparam int CNT_SEU       = 9;
  localparam int NUM_CNT       = 10;

  function automatic data_type_e classify(input logic [39:0] rec, input logic [15:0] marker);
    if (rec[39]) return TYPE_DATA;
    if (rec[39:22] == {marker, 2'b00}) return TYPE_HEADER;
    if (rec[39:22] == {marker, 2'b10}) return TYPE_IDLE;
    return TYPE_TRAILER;
  endfunction

  // MSB-first CRC-8 update over one full record; a record ending in the CRC
  // of everything before it leaves a zero residue.
  function automatic logic [7:0] crc8_fold(input logic [7:0] crc, input logic [CRC_WORD_W-1:0] word);
    logic [7:0] c;
    c = crc;
    for (int i = CRC_WORD_W - 1; i >= 0; i--) begin
      if (c[7] ^ word[i]) c = {c[6:0], 1'b0} ^ CRC_POLY;
      else                c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter with synchronous clear that either saturates at all-ones
// or wraps, selected by SATURATE.
module sat_counter #(
  parameter int W        = 20,
  parameter int SATURATE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset || clr) count <= '0;
    else if (inc && !((SATURATE != 0) && (&count))) count <= count + 1'b1;
  end

endmodule

// File: rtl/readout_frame_checker.sv
// Two-stage readout record checker: classify each valid record, then track
// frame structure, CRC, hit count and BCID, and accumulate statistics.
module readout_frame_checker
  import readout_check_pkg::*;
#(
  parameter logic [15:0] HDR_MARKER  = HDR_MARKER_DEF,
  parameter int          CNT_W       = 20,
  parameter int          RATE_WINDOW = 64,
  parameter int          RATE_W      = 10,
  parameter int          SATURATE    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [39:0]       dataRecord,
  input  logic              dataValid,
  input  logic              clearCounters,
  output logic [1:0]        dataType,
  output logic [2:0]        frameError,
  output logic              frameErrorValid,
  output logic [CNT_W-1:0]  goodEventCount,
  output logic [CNT_W-1:0]  notHitEventCount,
  output logic [CNT_W-1:0]  nullEventCount,
  output logic [CNT_W-1:0]  frameErrorCount,
  output logic [CNT_W-1:0]  bcidErrorCount,
  output logic [CNT_W-1:0]  hitCountMismatchCount,
  output logic [CNT_W-1:0]  L1OverflowEventCount,
  output logic [CNT_W-1:0]  L1FullEventCount,
  output logic [CNT_W-1:0]  L1HalfFullEventCount,
  output logic [CNT_W-1:0]  SEUEventCount,
  output logic [RATE_W-1:0] goodEventRate,
  output logic [7:0]        stickyErrors,
  output logic [2:0]        firstErrorCode,
  output logic [39:0]       firstErrorRecord
);

  localparam logic [9:0] WIN_LAST = 10'(RATE_WINDOW - 1);

  logic              vld_p1;
  logic [39:0]       rec_p1;
  data_type_e        type_p1;
  logic              vld_p2;
  frame_err_e        err_p2;
  logic              sess;
  logic [7:0]        hits;
  logic [7:0]        crc;
  logic [BCID_W-1:0] bcid;
  logic [9:0]        win_cnt;
  logic [RATE_W-1:0] win_good;
  logic [RATE_W-1:0] rate;
  logic [7:0]        sticky;
  logic              captured;
  logic [2:0]        first_code;
  logic [39:0]       first_rec;

  frame_err_e        code;
  logic              sess_n;
  logic [7:0]        hits_n;
  logic [7:0]        crc_n;
  logic [7:0]        crc_fold;
  logic [BCID_W-1:0] bcid_n;
  logic              bcid_err;
  logic [7:0]        trl_cnt;
  logic [1:0]        trl_l1;
  logic [NUM_CNT-1:0]    inc;
  logic [CNT_W-1:0]      cnt [NUM_CNT];

  // ---- stage 1: register and classify ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_p1  <= 1'b0;
      rec_p1  <= '0;
      type_p1 <= TYPE_IDLE;
    end else begin
      vld_p1 <= dataValid;
      if (dataValid) begin
        rec_p1  <= dataRecord;
        type_p1 <= classify(dataRecord, HDR_MARKER);
      end
    end
  end

  // ---- stage 2: frame checks ----
  always_comb begin
    code     = ERR_GOOD;
    sess_n   = sess;
    hits_n   = hits;
    crc_n    = crc;
    bcid_n   = bcid;
    bcid_err = 1'b0;
    inc      = '0;
    crc_fold = crc8_fold(crc, rec_p1);
    trl_cnt  = rec_p1[TRL_CNT_LO +: 8];
    trl_l1   = rec_p1[TRL_L1_LO +: 2];
    if (vld_p1) begin
      case (type_p1)
        TYPE_HEADER: begin
          code   = sess ? ERR_NO_TRAILER : ERR_GOOD;
          sess_n = 1'b1;
          hits_n = 8'd0;
          bcid_n = rec_p1[HDR_BCID_LO +: BCID_W];
          crc_n  = crc8_fold(8'h00, rec_p1);
        end
        TYPE_DATA: begin
          code     = sess ? ERR_GOOD : ERR_NO_HEADER;
          hits_n   = (hits == 8'hFF) ? hits : hits + 8'd1;
          crc_n    = crc_fold;
          bcid_err = (rec_p1[DATA_BCID_LO +: BCID_W] != bcid);
        end
        TYPE_TRAILER: begin
          sess_n = 1'b0;
          crc_n  = 8'h00;
          if (!sess)                        code = ERR_NO_HEADER;
          else if (trl_cnt != hits)         code = ERR_COUNT_MISMATCH;
          else if (crc_fold != 8'h00)       code = ERR_CRC_MISMATCH;
          else if (trl_l1[1] && hits != 0)  code = ERR_OVERFLOW;
          else inc[CNT_GOOD] = (hits != 8'd0);
          inc[CNT_NOT_HIT] = (hits == 8'd0);
          inc[CNT_L1_OVF]  = (trl_l1 == 2'b10);
          inc[CNT_L1_HALF] = (trl_l1 == 2'b01);
          inc[CNT_L1_FULL] = (trl_l1 == 2'b11);
          inc[CNT_SEU]     = rec_p1[TRL_SEU_BIT];
          inc[CNT_HIT_MIS] = (trl_cnt != hits);
        end
        TYPE_IDLE: begin
          if (sess)                                    code = ERR_NO_TRAILER;
          else if (rec_p1[39:22] != {HDR_MARKER, 2'b10}) code = ERR_IDLE;
          inc[CNT_NULL] = 1'b1;
        end
      endcase
      inc[CNT_FRAME_ERR] = (code != ERR_GOOD);
      inc[CNT_BCID]      = bcid_err;
    end
  end

  // Frame state survives clearCounters so in-flight frames stay coherent
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_p2 <= 1'b0;
      err_p2 <= ERR_GOOD;
      sess   <= 1'b0;
      hits   <= '0;
      crc    <= '0;
      bcid   <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        err_p2 <= code;
        sess   <= sess_n;
        hits   <= hits_n;
        crc    <= crc_n;
        bcid   <= bcid_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || clearCounters) begin
      win_cnt    <= '0;
      win_good   <= '0;
      rate       <= '0;
      sticky     <= '0;
      captured   <= 1'b0;
      first_code <= '0;
      first_rec  <= '0;
    end else if (vld_p1) begin
      if (win_cnt == WIN_LAST) begin
        rate     <= win_good + RATE_W'(code == ERR_GOOD);
        win_cnt  <= '0;
        win_good <= '0;
      end else begin
        win_cnt  <= win_cnt + 10'd1;
        win_good <= win_good + RATE_W'(code == ERR_GOOD);
      end
      if (bcid_err) sticky[0] <= 1'b1;
      if (code != ERR_GOOD) begin
        sticky[code] <= 1'b1;
        if (!captured) begin
          captured   <= 1'b1;
          first_code <= code;
          first_rec  <= rec_p1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    sat_counter #(.W(CNT_W), .SATURATE(SATURATE)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (clearCounters),
      .inc   (inc[g]),
      .count (cnt[g])
    );
  end

  assign dataType              = type_p1;
  assign frameError            = err_p2;
  assign frameErrorValid       = vld_p2;
  assign goodEventCount        = cnt[CNT_GOOD];
  assign notHitEventCount      = cnt[CNT_NOT_HIT];
  assign nullEventCount        = cnt[CNT_NULL];
  assign frameErrorCount       = cnt[CNT_FRAME_ERR];
  assign bcidErrorCount        = cnt[CNT_BCID];
  assign hitCountMismatchCount = cnt[CNT_HIT_MIS];
  assign L1OverflowEventCount  = cnt[CNT_L1_OVF];
  assign L1FullEventCount      = cnt[CNT_L1_FULL];
  assign L1HalfFullEventCount  = cnt[CNT_L1_HALF];
  assign SEUEventCount         = cnt[CNT_SEU];
  assign goodEventRate         = rate;
  assign stickyErrors          = sticky;
  assign firstErrorCode        = first_code;
  assign firstErrorRecord      = first_rec;

endmodule

// File: tb/tb_readout_frame_checker.sv
// Directed bench for readout_frame_checker: per-record frameError codes are
// queued at drive time and compared as they emerge; counters checked after draining.
module tb_readout_frame_checker;

  localparam logic [15:0] MK       = 16'h3C5C;
  localparam logic [39:0] IDLE_REC = {MK, 2'b10, 22'h0};

  logic        clk = 1'b0;
  logic        reset, dataValid, clearCounters;
  logic [39:0] dataRecord;

  logic [1:0]  dataType, w_dataType;
  logic [2:0]  frameError, w_frameError, firstErrorCode, w_firstErrorCode;
  logic        frameErrorValid, w_frameErrorValid;
  logic [3:0]  good, nothit, nul, ferr, bcid, hmis, ovf, full, half, seu;
  logic [3:0]  w_good, w_nothit, w_nul, w_ferr, w_bcid, w_hmis, w_ovf, w_full, w_half, w_seu;
  logic [9:0]  rate, w_rate;
  logic [7:0]  sticky, w_sticky;
  logic [39:0] first_rec, w_first_rec;

  int          errors = 0;
  int          checks = 0;
  logic [2:0]  sb [$];
  logic [7:0]  crc_m = 8'h00;

  always #12 clk = ~clk;

  readout_frame_checker #(.CNT_W(4), .RATE_WINDOW(8), .SATURATE(1)) dut (
    .clk(clk), .reset(reset), .dataRecord(dataRecord), .dataValid(dataValid),
    .clearCounters(clearCounters), .dataType(dataType), .frameError(frameError),
    .frameErrorValid(frameErrorValid), .goodEventCount(good), .notHitEventCount(nothit),
    .nullEventCount(nul), .frameErrorCount(ferr), .bcidErrorCount(bcid),
    .hitCountMismatchCount(hmis), .L1OverflowEventCount(ovf), .L1FullEventCount(full),
    .L1HalfFullEventCount(half), .SEUEventCount(seu), .goodEventRate(rate),
    .stickyErrors(sticky), .firstErrorCode(firstErrorCode), .firstErrorRecord(first_rec)
  );

  readout_frame_checker #(.CNT_W(4), .RATE_WINDOW(8), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .dataRecord(dataRecord), .dataValid(dataValid),
    .clearCounters(clearCounters), .dataType(w_dataType), .frameError(w_frameError),
    .frameErrorValid(w_frameErrorValid), .goodEventCount(w_good), .notHitEventCount(w_nothit),
    .nullEventCount(w_nul), .frameErrorCount(w_ferr), .bcidErrorCount(w_bcid),
    .hitCountMismatchCount(w_hmis), .L1OverflowEventCount(w_ovf), .L1FullEventCount(w_full),
    .L1HalfFullEventCount(w_half), .SEUEventCount(w_seu), .goodEventRate(w_rate),
    .stickyErrors(w_sticky), .firstErrorCode(w_firstErrorCode), .firstErrorRecord(w_first_rec)
  );

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference CRC-8 (x^8+x^2+x+1, MSB first) over the top n bits of d
  function automatic logic [7:0] crc_upd(input logic [7:0] c, input logic [39:0] d, input int n);
    logic [7:0] s;
    logic       fb;
    s = c;
    for (int i = 39; i >= 40 - n; i--) begin
      fb = s[7] ^ d[i];
      s  = {s[6:0], 1'b0};
      if (fb) s = s ^ 8'h07;
    end
    return s;
  endfunction

  task automatic send(input logic [39:0] rec, input logic [1:0] typ, input logic [2:0] code);
    dataRecord = rec;
    dataValid  = 1'b1;
    sb.push_back(code);
    @(posedge clk);
    @(negedge clk);
    chk("dataType", 40'(dataType), 40'(typ));
    dataValid = 1'b0;
  endtask

  task automatic hdr(input logic [11:0] b, input logic [2:0] code);
    logic [39:0] r;
    r = {MK, 2'b00, 10'h0, b};
    crc_m = crc_upd(8'h00, r, 40);
    send(r, 2'b00, code);
  endtask

  task automatic dat(input logic [11:0] b, input logic [2:0] code);
    logic [39:0] r;
    r = {1'b1, 18'h0, b, 9'h0};
    crc_m = crc_upd(crc_m, r, 40);
    send(r, 2'b01, code);
  endtask

  task automatic trl(input logic [1:0] st, input logic s, input logic [7:0] cnt,
                     input logic [7:0] flip, input logic [2:0] code);
    logic [39:0] r;
    r = {MK, 2'b01, st, s, 3'b000, cnt, 8'h00};
    r[7:0] = crc_upd(crc_m, r, 32) ^ flip;
    crc_m = 8'h00;
    send(r, 2'b10, code);
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_pulse();
    clearCounters = 1'b1;
    @(negedge clk);
    clearCounters = 1'b0;
  endtask

  always @(negedge clk) begin
    if (frameErrorValid) begin
      if (sb.size() == 0) chk("sb_underflow", 40'(sb.size()), 40'd1);
      else chk("frameError", 40'(frameError), 40'(sb.pop_front()));
    end
  end

  initial begin
    reset = 1'b0; dataValid = 1'b0; clearCounters = 1'b0; dataRecord = '0;
    gap(3);
    chk("rst_dataType", 40'(dataType), 40'd3);
    chk("rst_valid", 40'(frameErrorValid), 40'd0);
    chk("rst_good", 40'(good), 40'd0);
    chk("rst_sticky", 40'(sticky), 40'd0);
    chk("rst_first_rec", first_rec, 40'd0);
    reset = 1'b1;
    gap(1);

    // clean frame
    hdr(12'h123, 3'd0);
    repeat (3) dat(12'h123, 3'd0);
    trl(2'b00, 1'b0, 8'd3, 8'h00, 3'd0);
    gap(4);
    chk("t1_good", 40'(good), 40'd1);
    chk("t1_sticky", 40'(sticky), 40'd0);
    chk("t1_ferr", 40'(ferr), 40'd0);
    chk("t1_nothit", 40'(nothit), 40'd0);

    // header without trailer
    hdr(12'h123, 3'd0);
    hdr(12'h456, 3'd1);
    trl(2'b00, 1'b0, 8'd0, 8'h00, 3'd0);
    gap(4);
    chk("t2_first_code", 40'(firstErrorCode), 40'd1);
    chk("t2_first_rec", first_rec, {MK, 2'b00, 10'h0, 12'h456});
    chk("t2_ferr", 40'(ferr), 40'd1);
    chk("t2_good", 40'(good), 40'd1);
    chk("t2_nothit", 40'(nothit), 40'd1);
    chk("t2_sticky", 40'(sticky), 40'h02);

    // count mismatch, CRC error, overflow, half-full with SEU
    clear_pulse();
    hdr(12'h123, 3'd0); repeat (3) dat(12'h123, 3'd0);
    trl(2'b00, 1'b0, 8'd2, 8'h00, 3'd3);
    hdr(12'h123, 3'd0); repeat (3) dat(12'h123, 3'd0);
    trl(2'b00, 1'b0, 8'd3, 8'h01, 3'd4);
    hdr(12'h123, 3'd0); dat(12'h123, 3'd0);
    trl(2'b10, 1'b0, 8'd1, 8'h00, 3'd7);
    hdr(12'h123, 3'd0); dat(12'h123, 3'd0);
    trl(2'b01, 1'b1, 8'd1, 8'h00, 3'd0);
    gap(4);
    chk("t3_hmis", 40'(hmis), 40'd1);
    chk("t3_ferr", 40'(ferr), 40'd3);
    chk("t3_sticky", 40'(sticky), 40'h98);
    chk("t3_first_code", 40'(firstErrorCode), 40'd3);
    chk("t3_ovf", 40'(ovf), 40'd1);
    chk("t3_half", 40'(half), 40'd1);
    chk("t3_full", 40'(full), 40'd0);
    chk("t3_seu", 40'(seu), 40'd1);
    chk("t3_good", 40'(good), 40'd1);

    // BCID mismatch, trailer outside a frame, idle inside a frame
    clear_pulse();
    hdr(12'h123, 3'd0); dat(12'h124, 3'd0);
    trl(2'b00, 1'b0, 8'd1, 8'h00, 3'd0);
    trl(2'b00, 1'b0, 8'd0, 8'h00, 3'd2);
    hdr(12'h123, 3'd0);
    send(IDLE_REC, 2'b11, 3'd1);
    trl(2'b00, 1'b0, 8'd0, 8'h00, 3'd0);
    gap(4);
    chk("t4_bcid", 40'(bcid), 40'd1);
    chk("t4_sticky", 40'(sticky), 40'h07);
    chk("t4_ferr", 40'(ferr), 40'd2);
    chk("t4_good", 40'(good), 40'd1);
    chk("t4_nothit", 40'(nothit), 40'd1);
    chk("t4_first_code", 40'(firstErrorCode), 40'd2);

    // saturate versus wrap
    clear_pulse();
    repeat (20) send(IDLE_REC, 2'b11, 3'd0);
    gap(4);
    chk("t5_null_sat", 40'(nul), 40'd15);
    chk("t5_null_wrap", 40'(w_nul), 40'd4);

    // rate window with dataValid toggling
    clear_pulse();
    repeat (7) begin send(IDLE_REC, 2'b11, 3'd0); gap(1); end
    gap(3);
    chk("t6_rate_pre", 40'(rate), 40'd0);
    send(IDLE_REC, 2'b11, 3'd0);
    gap(4);
    chk("t6_rate_w1", 40'(rate), 40'd8);
    hdr(12'h321, 3'd0); gap(1);
    send(IDLE_REC, 2'b11, 3'd1); gap(1);
    trl(2'b00, 1'b0, 8'd0, 8'h00, 3'd0); gap(1);
    repeat (4) begin send(IDLE_REC, 2'b11, 3'd0); gap(1); end
    gap(3);
    chk("t6_rate_hold", 40'(rate), 40'd8);
    send(IDLE_REC, 2'b11, 3'd0);
    gap(4);
    chk("t6_rate_w2", 40'(rate), 40'd7);

    // clear in the same cycle as an increment
    chk("t7_null_before", 40'(nul), 40'd14);
    dataRecord = IDLE_REC;
    dataValid  = 1'b1;
    sb.push_back(3'd0);
    @(posedge clk);
    @(negedge clk);
    dataValid     = 1'b0;
    clearCounters = 1'b1;
    @(negedge clk);
    clearCounters = 1'b0;
    gap(3);
    chk("t7_null", 40'(nul), 40'd0);
    chk("t7_rate", 40'(rate), 40'd0);
    chk("t7_sticky", 40'(sticky), 40'd0);

    chk("sb_drained", 40'(sb.size()), 40'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/readout_frame_checker.md
Name: readout_frame_checker

Overview:
- Parametrised successor of the ETROC2 readout data-record checker.
- Classifies each 40-bit readout record as header, data, trailer or idle, and checks frame structure, hit count, running CRC, BCID consistency and L1 status.
- Accumulates saturating event/error counters and a configurable-window good-frame rate.
- Sits on the receive side of the readout test chain, after word alignment. Adds valid gating, counter clear, first-error capture and sticky error flags.

Parameters:
- HDR_MARKER, 16'h3C5C, marker in bits [39:24] of header, trailer and idle records.
- CNT_W, 20, width of every event/error counter.
- RATE_WINDOW, 64, number of valid records per good-rate window (2..1023).
- RATE_W, 10, width of goodEventRate.
- SATURATE, 1, 1 = counters stop at all-ones; 0 = counters wrap.

Ports:
- clk  in  1  40 MHz clock
- reset  in  1  synchronous, active-low
- dataRecord  in  40  readout record
- dataValid  in  1  record qualifier; cycles with 0 are ignored entirely
- clearCounters  in  1  synchronous clear of counters, flags and capture; frame state is kept
- dataType  out  2  00 header, 01 data, 10 trailer, 11 idle
- frameError  out  3  per-record error code (see Behaviour)
- frameErrorValid  out  1  frameError refers to a new record this cycle
- goodEventCount, notHitEventCount, nullEventCount, frameErrorCount, bcidErrorCount, hitCountMismatchCount, L1OverflowEventCount, L1FullEventCount, L1HalfFullEventCount, SEUEventCount  out  CNT_W each  event counters
- goodEventRate  out  RATE_W  good frames in the last completed window
- stickyErrors  out  8  one bit per frameError code 1..7, plus bit 0 = BCID error
- firstErrorCode  out  3  code of the first error since reset/clear
- firstErrorRecord  out  40  record that caused it

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (reset).
- Reset (reset==0 at clk edge): every output and internal register goes to 0, except dataType=11 (idle). clearCounters==1 has the same effect on counters, goodEventRate, window state, stickyErrors and first-error capture, but not on sessionStart, CRC or hitsCount.
- Stage 1 (1 cycle), when dataValid: register the record and classify it, in priority order:
  - bit39=1 → data
  - [39:22]=={HDR_MARKER,00} → header
  - [39:22]=={HDR_MARKER,10} → idle
  - else → trailer
- Stage 2 (1 cycle): updates state, counters and frameError, so frameError appears 2 cycles after the input. frameErrorValid is dataValid delayed by 2 cycles.
- Record fields:
  - header BCID = [11:0]
  - data BCID = [20:9]
  - trailer: L1 status [21:20], SEU [19], hit count [15:8], CRC [7:0]
- Error codes: 0 good, 1 noTrailer, 2 noHeader, 3 countMismatch, 4 CRCMismatch, 5 headerError (reserved), 6 idleError, 7 overflowData.
- Frame state: one sessionStart bit.
  - Header: if sessionStart, code 1; else 0. Then sessionStart=1, hitsCount=0, latch BCID, fold record into CRC.
  - Data: if !sessionStart, code 2; else 0. hitsCount+1, saturating at 255. Fold record into CRC. If BCID differs from the latched BCID, bcidErrorCount+1 and stickyErrors[0]=1.
  - Trailer: fold into CRC; sessionStart=0. Checks in priority order: !sessionStart→2; count≠hitsCount→3; CRC residue≠0→4; [21]=1 and hitsCount≠0→7; else 0, and goodEventCount+1 if hitsCount≥1. Independently of frameError:
    - notHit+1 if hitsCount==0
    - L1Overflow / HalfFull / Full +1 for status 10 / 01 / 11
    - SEU+1 if bit19
    - hitCountMismatch+1 if count≠hitsCount
    - After the trailer, CRC resets to 0.
  - Idle: sessionStart→1; [39:22] mismatch→6 (only reachable via aligned-idle variants); else 0. nullEventCount+1. CRC is not advanced.
- CRC: CRC-8 over the 40-bit record with the existing polynomial, seeded 0 at header.
- Counters: frameErrorCount+1 per nonzero code. All counters saturate at 2^CNT_W-1 when SATURATE=1 and wrap when SATURATE=0.
- Error capture: every nonzero code sets its stickyErrors bit. The first nonzero code and its record are captured once and held until reset or clear.
- Rate window: counts valid records. On the RATE_WINDOW-th record, goodEventRate = good frames in the window, including that record; the window then restarts. Invalid cycles do not advance the window.
- Simultaneous events: clearCounters wins over any increment in the same cycle. Records already in the pipeline are still processed against the cleared counters.

Decomposition:
- Package readout_check_pkg: dataType encodings, frameError codes, record field bit positions, HDR_MARKER default.
- Sub-module sat_counter: parameterised width and SATURATE, with inc/clr inputs; instantiated once per counter.
- Reuse the existing CRC8 with WORDWIDTH=40.

Test Plan:
- Reset, then header, 3 data (matching BCID 0x123), trailer with count 3 and a valid CRC → frameError 0 on all records; goodEventCount=1; stickyErrors=0.
- Header, header, trailer → second header gives code 1; firstErrorCode=1 and firstErrorRecord = second header; frameErrorCount=1.
- Trailer with count 2 after 3 data records → code 3; hitCountMismatchCount=1. Corrupt one CRC bit with count correct → code 4.
- Data with BCID 0x124 after header BCID 0x123 → bcidErrorCount=1; stickyErrors[0]=1; frameError 0.
- CNT_W=4, SATURATE=1, 20 idles → nullEventCount=15. Repeat with SATURATE=0 → nullEventCount=4.
- RATE_WINDOW=8, 16 good idles with dataValid toggling → goodEventRate=8 after the 8th valid record. Pulse clearCounters coincident with an increment → counter reads 0.
